i2s_tx: RTL and testbench



---
 rtl/i2s_pkg.sv | 23 ++
 rtl/i2s_sat_scale.sv | 45 ++++
 rtl/i2s_tx.sv | 138 +++++++++++++
 tb/tb_i2s_tx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S transmitter slice.
// Defaults lock one stereo frame to the FM sample period of the mixer.
package i2s_pkg;

  localparam int CLK_JT_HZ     = 53_703_700;
  localparam int FS_DIV        = 864;
  localparam int DEF_IN_WIDTH  = 19;
  localparam int DEF_OUT_BITS  = 24;
  localparam int DEF_SLOT_BITS = 36;
  localparam int DEF_BCLK_HALF = 6;

  typedef struct packed {
    logic frame_start;
    logic overrun;
    logic underrun;
  } i2s_evt_t;

  // Two slots of SLOT_BITS bit clocks, each bit clock two half-periods.
  function automatic bit i2s_rate_ok(input int slot_bits, input int bclk_half);
    return (2 * slot_bits * 2 * bclk_half) == FS_DIV;
  endfunction

endpackage

// File: rtl/i2s_sat_scale.sv
// Per-channel gain, saturation to the input range and justification to the
// I2S word width. Purely combinational.
module i2s_sat_scale #(
  parameter int IN_WIDTH = 19,
  parameter int OUT_BITS = 24,
  parameter int GAIN     = 0
) (
  input  logic signed [IN_WIDTH-1:0] din,
  output logic signed [OUT_BITS-1:0] dout
);

  // Four guard bits cover the largest allowed gain shift.
  localparam int WW = IN_WIDTH + 4;
  localparam logic signed [WW-1:0] MAXV = WW'((64'sd1 <<< (IN_WIDTH - 1)) - 64'sd1);
  localparam logic signed [WW-1:0] MINV = WW'(-(64'sd1 <<< (IN_WIDTH - 1)));

  logic signed [WW-1:0]       ext;
  logic signed [WW-1:0]       wide;
  logic signed [IN_WIDTH-1:0] g;

  always_comb begin
    ext  = {{4{din[IN_WIDTH-1]}}, din};
    wide = ext <<< GAIN;
    if (wide > MAXV) begin
      g = MAXV[IN_WIDTH-1:0];
    end else if (wide < MINV) begin
      g = MINV[IN_WIDTH-1:0];
    end else begin
      g = wide[IN_WIDTH-1:0];
    end
  end

  generate
    if (OUT_BITS == IN_WIDTH) begin : g_same
      assign dout = g;
    end else if (OUT_BITS > IN_WIDTH) begin : g_left
      assign dout = {g, {(OUT_BITS - IN_WIDTH){1'b0}}};
    end else begin : g_right
      logic signed [IN_WIDTH-1:0] sh;
      assign sh   = g >>> (IN_WIDTH - OUT_BITS);
      assign dout = sh[OUT_BITS-1:0];
    end
  endgenerate

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: captures the mixer sample on the strobe's rising
// edge, double-buffers it and serialises a free-running BCLK/LRCLK/SDATA frame.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int IN_WIDTH    = DEF_IN_WIDTH,
  parameter int OUT_BITS    = DEF_OUT_BITS,
  parameter int SLOT_BITS   = DEF_SLOT_BITS,
  parameter int BCLK_HALF   = DEF_BCLK_HALF,
  parameter int GAIN        = 0,
  parameter bit RATE_LOCKED = 1'b1
) (
  input  logic                       clk_jt,
  input  logic                       rst,
  input  logic signed [IN_WIDTH-1:0] snd_left,
  input  logic signed [IN_WIDTH-1:0] snd_right,
  input  logic                       snd_sample,
  input  logic                       clr_flags,
  output logic                       i2s_bclk,
  output logic                       i2s_lrclk,
  output logic                       i2s_sdata,
  output logic                       frame_start,
  output logic                       overrun,
  output logic                       underrun,
  output logic                       ovr_sticky,
  output logic                       udr_sticky
);

  generate
    if (RATE_LOCKED && !i2s_rate_ok(SLOT_BITS, BCLK_HALF)) begin : g_rate_err
      $error("i2s_tx: frame period does not equal FS_DIV clk_jt cycles");
    end
    if (SLOT_BITS < OUT_BITS + 1 || BCLK_HALF < 2 || GAIN < 0 || GAIN > 4) begin : g_param_err
      $error("i2s_tx: illegal SLOT_BITS, BCLK_HALF or GAIN");
    end
  endgenerate

  localparam int HW = $clog2(BCLK_HALF);
  localparam int BW = $clog2(2 * SLOT_BITS);
  localparam logic [HW-1:0] HALF_LAST = HW'(BCLK_HALF - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0] SLOT_W    = BW'(SLOT_BITS);
  localparam logic [BW-1:0] OUT_W     = BW'(OUT_BITS);

  logic signed [OUT_BITS-1:0] scaled_l, scaled_r;
  logic [OUT_BITS-1:0]        pend_l, pend_r, word_l, word_r;
  logic                       pend_valid;
  logic                       snd_prev;
  logic [HW-1:0]              half_cnt;
  logic [BW-1:0]              bit_cnt;

  i2s_sat_scale #(.IN_WIDTH(IN_WIDTH), .OUT_BITS(OUT_BITS), .GAIN(GAIN)) u_scale_l (
    .din  (snd_left),
    .dout (scaled_l)
  );

  i2s_sat_scale #(.IN_WIDTH(IN_WIDTH), .OUT_BITS(OUT_BITS), .GAIN(GAIN)) u_scale_r (
    .din  (snd_right),
    .dout (scaled_r)
  );

  logic                rise, bclk_fall, load;
  logic [BW-1:0]       bit_nxt, pos;
  logic                lr_nxt, sd_nxt;
  logic [OUT_BITS-1:0] word_sel, word_sh;
  i2s_evt_t            evt;

  // Serial outputs are computed from the bit position being entered at the fall.
  always_comb begin
    rise      = snd_sample & ~snd_prev;
    bclk_fall = (half_cnt == HALF_LAST) & i2s_bclk;
    load      = bclk_fall & (bit_cnt == BIT_LAST);
    bit_nxt   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    lr_nxt    = (bit_nxt >= SLOT_W);
    pos       = lr_nxt ? bit_nxt - SLOT_W : bit_nxt;
    word_sel  = lr_nxt ? word_r : word_l;
    word_sh   = word_sel << (pos - 1'b1);
    sd_nxt    = 1'b0;
    if (pos >= BW'(1) && pos <= OUT_W) begin
      sd_nxt = word_sh[OUT_BITS-1];
    end
    evt.frame_start = load;
    evt.underrun    = load & ~pend_valid;
    evt.overrun     = rise & pend_valid & ~load;
  end

  always_ff @(posedge clk_jt) begin
    if (rst) begin
      snd_prev    <= 1'b0;
      half_cnt    <= '0;
      bit_cnt     <= '0;
      i2s_bclk    <= 1'b0;
      i2s_lrclk   <= 1'b0;
      i2s_sdata   <= 1'b0;
      pend_l      <= '0;
      pend_r      <= '0;
      pend_valid  <= 1'b0;
      word_l      <= '0;
      word_r      <= '0;
      frame_start <= 1'b0;
      overrun     <= 1'b0;
      underrun    <= 1'b0;
      ovr_sticky  <= 1'b0;
      udr_sticky  <= 1'b0;
    end else begin
      snd_prev <= snd_sample;
      if (half_cnt == HALF_LAST) begin
        half_cnt <= '0;
        i2s_bclk <= ~i2s_bclk;
      end else begin
        half_cnt <= half_cnt + 1'b1;
      end
      if (bclk_fall) begin
        bit_cnt   <= bit_nxt;
        i2s_lrclk <= lr_nxt;
        i2s_sdata <= sd_nxt;
      end
      // The load sees the pre-cycle pending state; a same-cycle capture stays pending.
      if (load && pend_valid) begin
        word_l <= pend_l;
        word_r <= pend_r;
      end
      if (rise) begin
        pend_l     <= scaled_l;
        pend_r     <= scaled_r;
        pend_valid <= 1'b1;
      end else if (load) begin
        pend_valid <= 1'b0;
      end
      frame_start <= evt.frame_start;
      overrun     <= evt.overrun;
      underrun    <= evt.underrun;
      ovr_sticky  <= evt.overrun  | (ovr_sticky & ~clr_flags);
      udr_sticky  <= evt.underrun | (udr_sticky & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: default instance plus a GAIN=2 instance sharing
// the same stimulus; decoded frames are checked against hand-computed words.
module tb_i2s_tx;

  logic        clk_jt = 1'b0;
  logic        rst = 1'b1;
  logic [18:0] snd_left = '0;
  logic [18:0] snd_right = '0;
  logic        snd_sample = 1'b0;
  logic        clr_flags = 1'b0;

  logic bclk0, lrclk0, sdata0, fs0, ovr0, udr0, ovs0, uds0;
  logic bclk1, lrclk1, sdata1, fs1, ovr1, udr1, ovs1, uds1;

  int n_checks = 0;
  int n_pass = 0;
  logic [23:0] exp_q[$];

  always #5 clk_jt = ~clk_jt;

  i2s_tx dut (
    .clk_jt(clk_jt), .rst(rst), .snd_left(snd_left), .snd_right(snd_right),
    .snd_sample(snd_sample), .clr_flags(clr_flags),
    .i2s_bclk(bclk0), .i2s_lrclk(lrclk0), .i2s_sdata(sdata0), .frame_start(fs0),
    .overrun(ovr0), .underrun(udr0), .ovr_sticky(ovs0), .udr_sticky(uds0)
  );

  i2s_tx #(.GAIN(2)) dut_g2 (
    .clk_jt(clk_jt), .rst(rst), .snd_left(snd_left), .snd_right(snd_right),
    .snd_sample(snd_sample), .clr_flags(clr_flags),
    .i2s_bclk(bclk1), .i2s_lrclk(lrclk1), .i2s_sdata(sdata1), .frame_start(fs1),
    .overrun(ovr1), .underrun(udr1), .ovr_sticky(ovs1), .udr_sticky(uds1)
  );

  wire [7:0] outs0 = {bclk0, lrclk0, sdata0, fs0, ovr0, udr0, ovs0, uds0};
  wire [7:0] outs1 = {bclk1, lrclk1, sdata1, fs1, ovr1, udr1, ovs1, uds1};

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [23:0] word_at(input logic [71:0] b, input int base);
    logic [23:0] w;
    for (int i = 0; i < 24; i++) w[23-i] = b[base+i];
    return w;
  endfunction

  function automatic logic [71:0] pad_mask();
    logic [71:0] m;
    m = '0;
    for (int k = 0; k < 72; k++) if ((k % 36) == 0 || (k % 36) > 24) m[k] = 1'b1;
    return m;
  endfunction

  task automatic wait_frame(output logic udr, output logic ovr);
    int n;
    n = 0;
    do begin
      @(negedge clk_jt);
      n++;
    end while (fs0 !== 1'b1 && n < 1000);
    if (fs0 !== 1'b1) check("frame_timeout", 72'(fs0), 72'd1);
    udr = udr0;
    ovr = ovr0;
  endtask

  // Called on the frame_start cycle; bit k is sampled on the k-th BCLK rise.
  task automatic collect_bits(output logic [71:0] b0, output logic [71:0] b1);
    int k, n;
    logic prev;
    logic [71:0] lr;
    k = 0; n = 0; prev = bclk0; b0 = '0; b1 = '0; lr = '0;
    while (k < 72 && n < 2000) begin
      @(negedge clk_jt);
      n++;
      if (bclk0 && !prev) begin
        b0[k] = sdata0;
        b1[k] = sdata1;
        lr[k] = lrclk0;
        k++;
      end
      prev = bclk0;
    end
    if (k < 72) check("collect_timeout", 72'(k), 72'd72);
    check("lrclk_pattern", lr, 72'hFFFFFFFFF000000000);
  endtask

  task automatic collect_frame(output logic udr, output logic [71:0] b0, output logic [71:0] b1);
    logic ovr;
    wait_frame(udr, ovr);
    collect_bits(b0, b1);
  endtask

  task automatic check_words(input string tag, input logic [71:0] b);
    logic [23:0] el, er;
    el = exp_q.pop_front();
    er = exp_q.pop_front();
    check({tag, "_left"}, 72'(word_at(b, 1)), 72'(el));
    check({tag, "_right"}, 72'(word_at(b, 37)), 72'(er));
    check({tag, "_pad"}, b & pad_mask(), 72'd0);
  endtask

  task automatic pulse_sample(input logic [18:0] l, input logic [18:0] r, output logic ovr);
    snd_left = l;
    snd_right = r;
    snd_sample = 1'b1;
    @(negedge clk_jt);
    ovr = ovr0;
    snd_sample = 1'b0;
  endtask

  initial begin
    logic [71:0] b0, b1;
    logic udr, ovr;
    int first_rise, last_rise, prev_rise, lr_last, lr_prev, ones, fs_cnt, fs_bad;
    int ovr_cnt, udr_cnt, f;
    logic pb, plr;

    // 1: reset state, idle stream
    repeat (4) @(negedge clk_jt);
    check("reset_outs", 72'(outs0), 72'd0);
    check("reset_outs_g2", 72'(outs1), 72'd0);
    rst = 1'b0;
    first_rise = -1; last_rise = -1; prev_rise = -1; lr_last = -1; lr_prev = -1;
    ones = 0; fs_cnt = 0; fs_bad = 0; pb = 1'b0; plr = 1'b0;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk_jt);
      if (bclk0 && !pb) begin
        if (first_rise < 0) first_rise = c;
        prev_rise = last_rise;
        last_rise = c;
      end
      if (lrclk0 && !plr) begin
        lr_prev = lr_last;
        lr_last = c;
      end
      pb = bclk0;
      plr = lrclk0;
      if (sdata0) ones++;
      if (fs0) begin
        fs_cnt++;
        if (!udr0) fs_bad++;
      end
    end
    check("first_bclk_rise", 72'(first_rise), 72'd6);
    check("bclk_period", 72'(last_rise - prev_rise), 72'd12);
    check("lrclk_period", 72'(lr_last - lr_prev), 72'd864);
    check("idle_sdata_ones", 72'(ones), 72'd0);
    check("idle_frame_count", 72'(fs_cnt), 72'd2);
    check("idle_frames_without_underrun", 72'(fs_bad), 72'd0);
    check("idle_udr_sticky", 72'(uds0), 72'd1);
    check("idle_ovr_sticky", 72'(ovs0), 72'd0);

    // 2: +1 / -1 at both gains
    wait_frame(udr, ovr);
    pulse_sample(19'h00001, 19'h7FFFF, ovr);
    check("t2_overrun", 72'(ovr), 72'd0);
    exp_q.push_back(24'h000020); exp_q.push_back(24'hFFFFE0);
    exp_q.push_back(24'h000080); exp_q.push_back(24'hFFFF80);
    collect_frame(udr, b0, b1);
    check("t2_underrun", 72'(udr), 72'd0);
    check_words("t2", b0);
    check_words("t2_g2", b1);

    // 3: saturation under gain
    wait_frame(udr, ovr);
    pulse_sample(19'h10000, 19'h60000, ovr);
    exp_q.push_back(24'h200000); exp_q.push_back(24'hC00000);
    exp_q.push_back(24'h7FFFE0); exp_q.push_back(24'h800000);
    collect_frame(udr, b0, b1);
    check_words("t3", b0);
    check_words("t3_g2", b1);

    // 4: overrun within one frame, then sticky clear
    wait_frame(udr, ovr);
    pulse_sample(19'h00100, 19'h00200, ovr);
    check("t4_first_no_overrun", 72'(ovr), 72'd0);
    repeat (50) @(negedge clk_jt);
    pulse_sample(19'h01234, 19'h7ABCD, ovr);
    check("t4_overrun_pulse", 72'(ovr), 72'd1);
    check("t4_ovr_sticky", 72'(ovs0), 72'd1);
    @(negedge clk_jt);
    check("t4_overrun_one_cycle", 72'(ovr0), 72'd0);
    exp_q.push_back(24'h024680); exp_q.push_back(24'hF579A0);
    collect_frame(udr, b0, b1);
    check_words("t4", b0);
    wait_frame(udr, ovr);
    repeat (10) @(negedge clk_jt);
    clr_flags = 1'b1;
    @(negedge clk_jt);
    clr_flags = 1'b0;
    check("t4_clear_sticky", 72'({ovs0, uds0}), 72'd0);

    // 5: capture in the wrap cycle with nothing pending
    wait_frame(udr, ovr);
    repeat (863) @(negedge clk_jt);
    snd_left = 19'h3FFFF;
    snd_right = 19'h40000;
    snd_sample = 1'b1;
    @(negedge clk_jt);
    snd_sample = 1'b0;
    check("t5_wrap_flags", 72'({fs0, udr0, ovr0}), 72'b110);
    exp_q.push_back(24'h024680); exp_q.push_back(24'hF579A0);
    collect_bits(b0, b1);
    check_words("t5_repeat", b0);
    exp_q.push_back(24'h7FFFE0); exp_q.push_back(24'h800000);
    collect_frame(udr, b0, b1);
    check("t5_next_underrun", 72'(udr), 72'd0);
    check("t5_no_ovr_sticky", 72'(ovs0), 72'd0);
    check_words("t5_new", b0);

    // 6: rate-locked periodic strobe, then reset mid-frame
    wait_frame(udr, ovr);
    ovr_cnt = 0; udr_cnt = 0; f = 0;
    for (int c = 0; c < 80 * 864; c++) begin
      if (c % 864 == 300) begin
        snd_left = 19'(f * 1000);
        snd_right = 19'(-f * 1000);
        snd_sample = 1'b1;
        f++;
      end else begin
        snd_sample = 1'b0;
      end
      @(negedge clk_jt);
      if (c >= 864) begin
        if (ovr0) ovr_cnt++;
        if (udr0) udr_cnt++;
      end
    end
    snd_sample = 1'b0;
    check("t6_overrun_count", 72'(ovr_cnt), 72'd0);
    check("t6_underrun_count", 72'(udr_cnt), 72'd0);
    check("t6_frame_start", 72'(fs0), 72'd1);
    exp_q.push_back(24'h269300); exp_q.push_back(24'hD96D00);
    collect_bits(b0, b1);
    check_words("t6_last", b0);
    repeat (400) @(negedge clk_jt);
    check("t6_udr_sticky_before_reset", 72'(uds0), 72'd1);
    rst = 1'b1;
    @(negedge clk_jt);
    check("t6_reset_outs", 72'(outs0), 72'd0);
    check("t6_reset_outs_g2", 72'(outs1), 72'd0);
    rst = 1'b0;
    first_rise = -1; pb = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_jt);
      if (bclk0 && !pb && first_rise < 0) first_rise = c;
      pb = bclk0;
    end
    check("t6_restart_first_rise", 72'(first_rise), 72'd6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
